// File: rtl/usb3_rd_pkg.sv
// Shared constants for the FX3 slave-FIFO read path: FSM state encoding,
// idle strobe levels and the header mask/pattern used by the cache writer.
package usb3_rd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_FLAG_WAIT = 4'd2,
    ST_OE        = 4'd3,
    ST_PRIME     = 4'd4,
    ST_RSVD      = 4'd5,
    ST_STREAM    = 4'd6,
    ST_DONE      = 4'd7
  } rd_state_e;

  localparam logic        STROBE_IDLE   = 1'b1;
  localparam logic [1:0]  FIFO_ADDR_DEF = 2'b00;
  localparam logic [31:0] HDR_MASK      = 32'hff0000ff;
  localparam logic [31:0] HDR_PATTERN   = 32'hff0000aa;

  function automatic logic is_header(input logic [31:0] word);
    return (word & HDR_MASK) == HDR_PATTERN;
  endfunction

endpackage

// File: rtl/usb3_dq_capture.sv
// FX3 data input register plus a RD_LATENCY-deep valid pipeline that tracks
// which captured words correspond to issued read strobes.
module usb3_dq_capture #(
  parameter int RD_LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        slrd_n_i,
  input  logic [31:0] dq_i,
  output logic [31:0] data_o,
  output logic        valid_o
);

  logic [31:0]           data_q;
  logic [RD_LATENCY-1:0] vld_q;
  logic [RD_LATENCY-1:0] vld_d;

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign vld_d = ~slrd_n_i;
    end else begin : g_latn
      assign vld_d = {vld_q[RD_LATENCY-2:0], ~slrd_n_i};
    end
  endgenerate

  // Data register samples the bus every cycle; valid shifts with the strobe.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= 32'd0;
      vld_q  <= '0;
    end else begin
      data_q <= dq_i;
      vld_q  <= vld_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = vld_q[RD_LATENCY-1];

endmodule

// File: rtl/usb3_slave_fifo_rd.sv
// FX3 GPIF-II slave-FIFO read master: fixed-length bursts into a 32-bit stream.
// Optional statistics counters are enabled with `define USB3_RD_STATS_EN.
module usb3_slave_fifo_rd
  import usb3_rd_pkg::*;
#(
  parameter int         BURST_LEN   = 256,
  parameter int         RD_LATENCY  = 3,
  parameter int         FLAG_SETTLE = 3,
  parameter int         POST_GAP    = 4,
  parameter logic [1:0] FIFO_ADDR   = FIFO_ADDR_DEF
) (
  input  logic        wrclock,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        USB3_FLAGA,
  input  logic [31:0] USB3_DQ,
  output logic [1:0]  USB3_A,
  output logic        USB3_SLCS_N,
  output logic        USB3_SLOE_N,
  output logic        USB3_SLRD_N,
  output logic        USB3_SLWR_N,
  output logic        USB3_PKTEND_N,
  output logic [31:0] data,
  output logic [3:0]  usb_rd_state,
`ifdef USB3_RD_STATS_EN
  output logic [15:0] burst_cnt,
  output logic [15:0] abort_cnt,
`endif
  output logic        burst_done
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int TW = 8;

  rd_state_e     state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] iss_q, iss_d, cap_q, cap_d;
  logic          slcs_n_q, slcs_n_d, sloe_n_q, sloe_n_d, slrd_n_q, slrd_n_d;
  logic          done_q, done_d;
  logic          cap_valid;

  usb3_dq_capture #(.RD_LATENCY(RD_LATENCY)) u_cap (
    .clk_i    (wrclock),
    .rst_ni   (rst_n),
    .slrd_n_i (slrd_n_q),
    .dq_i     (USB3_DQ),
    .data_o   (data),
    .valid_o  (cap_valid)
  );

  // Next state, counters and strobe levels; strobes follow the next state.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    iss_d   = slrd_n_q ? iss_q : iss_q + CW'(1);
    cap_d   = cap_valid ? cap_q + CW'(1) : cap_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        iss_d = '0;
        cap_d = '0;
        if (rd_en && USB3_FLAGA) state_d = ST_ADDR;
        else                     state_d = ST_IDLE;
      end
      ST_ADDR: begin
        tmr_d   = '0;
        state_d = ST_FLAG_WAIT;
      end
      ST_FLAG_WAIT: begin
        if (tmr_q == TW'(FLAG_SETTLE - 1)) begin
          tmr_d   = '0;
          state_d = USB3_FLAGA ? ST_OE : ST_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_OE: begin
        tmr_d   = '0;
        state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (tmr_q == TW'(RD_LATENCY - 1)) begin
          tmr_d   = '0;
          state_d = ST_STREAM;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_STREAM: begin
        // cap_q counts words already delivered, so this is the last one
        if (cap_q >= CW'(BURST_LEN - 1)) begin
          tmr_d   = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DONE: begin
        if (tmr_q == TW'(POST_GAP - 1)) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        tmr_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    slcs_n_d = !(state_d inside {ST_ADDR, ST_FLAG_WAIT, ST_OE, ST_PRIME, ST_STREAM});
    sloe_n_d = !(state_d inside {ST_OE, ST_PRIME, ST_STREAM});
    if ((state_d inside {ST_PRIME, ST_STREAM}) && (iss_d < CW'(BURST_LEN))) slrd_n_d = 1'b0;
    else                                                                   slrd_n_d = STROBE_IDLE;
  end

  // State, counters and registered pin strobes.
  always_ff @(posedge wrclock) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      iss_q    <= '0;
      cap_q    <= '0;
      slcs_n_q <= STROBE_IDLE;
      sloe_n_q <= STROBE_IDLE;
      slrd_n_q <= STROBE_IDLE;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      iss_q    <= iss_d;
      cap_q    <= cap_d;
      slcs_n_q <= slcs_n_d;
      sloe_n_q <= sloe_n_d;
      slrd_n_q <= slrd_n_d;
      done_q   <= done_d;
    end
  end

`ifdef USB3_RD_STATS_EN
  logic [15:0] burst_cnt_q, abort_cnt_q;

  // Saturating completed-burst and FLAG_WAIT-abort counters.
  always_ff @(posedge wrclock) begin
    if (!rst_n) begin
      burst_cnt_q <= 16'd0;
      abort_cnt_q <= 16'd0;
    end else begin
      if (done_d && (burst_cnt_q != 16'hFFFF)) burst_cnt_q <= burst_cnt_q + 16'd1;
      if ((state_q == ST_FLAG_WAIT) && (state_d == ST_IDLE) && (abort_cnt_q != 16'hFFFF))
        abort_cnt_q <= abort_cnt_q + 16'd1;
    end
  end

  assign burst_cnt = burst_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif

  assign USB3_A        = FIFO_ADDR;
  assign USB3_SLCS_N   = slcs_n_q;
  assign USB3_SLOE_N   = sloe_n_q;
  assign USB3_SLRD_N   = slrd_n_q;
  assign USB3_SLWR_N   = STROBE_IDLE;
  assign USB3_PKTEND_N = STROBE_IDLE;
  assign usb_rd_state  = state_q;
  assign burst_done    = done_q;

endmodule

// File: tb/tb_usb3_slave_fifo_rd.sv
// Directed bench for usb3_slave_fifo_rd with an FX3 read model that returns
// an incrementing word for every read strobe. Build with USB3_RD_STATS_EN to check counters.
module tb_usb3_slave_fifo_rd;

  logic        clk = 1'b0;
  logic        rst_n, rd_en, flaga;
  logic [31:0] dq = 32'd0;
  logic [1:0]  usb_a;
  logic        slcs_n, sloe_n, slrd_n, slwr_n, pktend_n, burst_done;
  logic [31:0] data;
  logic [3:0]  state;
`ifdef USB3_RD_STATS_EN
  logic [15:0] burst_cnt, abort_cnt;
`endif

  usb3_slave_fifo_rd dut (
    .wrclock      (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .USB3_FLAGA   (flaga),
    .USB3_DQ      (dq),
    .USB3_A       (usb_a),
    .USB3_SLCS_N  (slcs_n),
    .USB3_SLOE_N  (sloe_n),
    .USB3_SLRD_N  (slrd_n),
    .USB3_SLWR_N  (slwr_n),
    .USB3_PKTEND_N(pktend_n),
    .data         (data),
    .usb_rd_state (state),
`ifdef USB3_RD_STATS_EN
    .burst_cnt    (burst_cnt),
    .abort_cnt    (abort_cnt),
`endif
    .burst_done   (burst_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // FX3 model plus monitor, all on the falling edge.
  int          strobe_cnt = 0, base = 0, widx = 0, done_cnt = 0, run_len = 0;
  logic [3:0]  prev_st = 4'd0;
  int          st_q[$];
  int          len_q[$];
  logic [31:0] pipe_w[2] = '{32'd0, 32'd0};
  logic        pipe_v[2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    if (pipe_v[1]) dq = pipe_w[1];
    pipe_v[1] = pipe_v[0];
    pipe_w[1] = pipe_w[0];
    pipe_v[0] = (slrd_n == 1'b0);
    pipe_w[0] = strobe_cnt;
    if (state == 4'd4 && prev_st != 4'd4) begin
      base = strobe_cnt;
      widx = 0;
    end
    if (state == 4'd6) begin
      check("data", data, base + widx);
      widx++;
    end
    if (slrd_n == 1'b0) strobe_cnt++;
    if (burst_done === 1'b1) done_cnt++;
    if (state == prev_st) run_len++;
    else begin
      st_q.push_back(prev_st);
      len_q.push_back(run_len);
      prev_st = state;
      run_len = 1;
    end
  end

  task automatic wait_st(input string tag, input logic [3:0] s, input int max);
    bit hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge clk);
      hit = (state == s);
    end
    check(tag, state, s);
  endtask

  // Finds the next burst (run of state 1) at or after 'from' and checks its run lengths.
  task automatic check_burst(input string tag, input int from, output int idx);
    int exp_st[6]  = '{1, 2, 3, 4, 6, 7};
    int exp_len[6] = '{1, 3, 1, 3, 256, 4};
    idx = -1;
    for (int i = from; i < st_q.size() && idx < 0; i++)
      if (st_q[i] == 1) idx = i;
    check({tag, "_found"}, (idx >= 0 && st_q.size() >= idx + 6), 1'b1);
    if (idx >= 0 && st_q.size() >= idx + 6) begin
      for (int j = 0; j < 6; j++) begin
        check({tag, "_st"}, st_q[idx + j], exp_st[j]);
        check({tag, "_len"}, len_q[idx + j], exp_len[j]);
      end
    end
  endtask

  int s0, d0, bi, bi2;

  initial begin
    // Reset with rd_en/FLAGA asserted
    rst_n = 1'b0; rd_en = 1'b1; flaga = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", state, 4'd0);
    check("rst_slcs", slcs_n, 1'b1);
    check("rst_sloe", sloe_n, 1'b1);
    check("rst_slrd", slrd_n, 1'b1);
    check("rst_slwr", slwr_n, 1'b1);
    check("rst_pktend", pktend_n, 1'b1);
    check("rst_addr", usb_a, 2'b00);
    check("rst_data", data, 32'd0);
    check("rst_done", burst_done, 1'b0);

    // Single burst
    st_q.delete(); len_q.delete();
    s0 = strobe_cnt; d0 = done_cnt;
    rst_n = 1'b1;
    wait_st("b1_start", 4'd1, 5);
    rd_en = 1'b0;
    wait_st("b1_done", 4'd7, 400);
    wait_st("b1_idle", 4'd0, 10);
    repeat (5) @(negedge clk);
    check_burst("b1", 0, bi);
    check("b1_strobes", strobe_cnt - s0, 256);
    check("b1_pulses", done_cnt - d0, 1);
    check("b1_stay_idle", state, 4'd0);

    // FLAGA drops during FLAG_WAIT
    st_q.delete(); len_q.delete();
    s0 = strobe_cnt;
    rd_en = 1'b1;
    wait_st("ab_start", 4'd1, 5);
    rd_en = 1'b0; flaga = 1'b0;
    wait_st("ab_idle", 4'd0, 10);
    check("ab_slcs", slcs_n, 1'b1);
    repeat (3) @(negedge clk);
    check("ab_run_st", (st_q.size() >= 2) ? st_q[st_q.size() - 1] : 0, 2);
    check("ab_run_len", (st_q.size() >= 2) ? len_q[len_q.size() - 1] : 0, 3);
    check("ab_strobes", strobe_cnt - s0, 0);
`ifdef USB3_RD_STATS_EN
    check("ab_abort_cnt", abort_cnt, 16'd1);
    check("ab_burst_cnt", burst_cnt, 16'd1);
`endif
    flaga = 1'b1;

    // rd_en falls at stream word 50
    st_q.delete(); len_q.delete();
    s0 = strobe_cnt; d0 = done_cnt;
    rd_en = 1'b1;
    wait_st("re_stream", 4'd6, 20);
    repeat (50) @(negedge clk);
    rd_en = 1'b0;
    wait_st("re_done", 4'd7, 400);
    wait_st("re_idle", 4'd0, 10);
    repeat (20) @(negedge clk);
    check("re_stay_idle", state, 4'd0);
    check_burst("re", 0, bi);
    check("re_strobes", strobe_cnt - s0, 256);
    check("re_pulses", done_cnt - d0, 1);

    // Reset at stream word 100, then a fresh burst
    rd_en = 1'b1;
    wait_st("mr_stream", 4'd6, 20);
    repeat (100) @(negedge clk);
    rd_en = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("mr_state", state, 4'd0);
    check("mr_slrd", slrd_n, 1'b1);
    check("mr_slcs", slcs_n, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    st_q.delete(); len_q.delete();
    s0 = strobe_cnt;
    rd_en = 1'b1;
    wait_st("mr_start", 4'd1, 5);
    rd_en = 1'b0;
    wait_st("mr_done", 4'd7, 400);
    wait_st("mr_idle", 4'd0, 10);
    repeat (3) @(negedge clk);
    check_burst("mr", 0, bi);
    check("mr_base", base, s0);
    check("mr_strobes", strobe_cnt - s0, 256);

    // Two back-to-back bursts from a clean reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    st_q.delete(); len_q.delete();
    d0 = done_cnt;
    rd_en = 1'b1;
    wait_st("bb_done1", 4'd7, 400);
    wait_st("bb_idle1", 4'd0, 10);
    wait_st("bb_done2", 4'd7, 400);
    rd_en = 1'b0;
    wait_st("bb_idle2", 4'd0, 10);
    repeat (5) @(negedge clk);
    check_burst("bb1", 0, bi);
    check_burst("bb2", bi + 1, bi2);
    check("bb_gap_idx", bi2 - bi, 7);
    check("bb_gap_st", (bi >= 0 && st_q.size() > bi + 6) ? st_q[bi + 6] : 99, 0);
    check("bb_gap_len", (bi >= 0 && len_q.size() > bi + 6) ? len_q[bi + 6] : 99, 1);
    check("bb_pulses", done_cnt - d0, 2);
`ifdef USB3_RD_STATS_EN
    check("bb_burst_cnt", burst_cnt, 16'd2);
    check("bb_abort_cnt", abort_cnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
